// File: rtl/conv_sched_if.sv
// Signal bundle between the conversion scheduler and its environment.
// The master side is the scheduler; the slave side is the sensor mux/core/result consumer.
interface conv_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 9
);
  localparam int CHW = $clog2(NCH);

  logic            en;
  logic [NCH-1:0]  ch_mask;
  logic [CHW-1:0]  ch_sel;
  logic            conv_start;
  logic            conv_done;
  logic [CW-1:0]   conv_count;
  logic            res_valid;
  logic [CHW-1:0]  res_ch;
  logic [CW-1:0]   res_data;
  logic            busy;
  logic            err_timeout;
  logic [2:0]      state_dbg;

  modport master (
    input  en, ch_mask, conv_done, conv_count,
    output ch_sel, conv_start, res_valid, res_ch, res_data, busy, err_timeout, state_dbg
  );

  modport slave (
    output en, ch_mask, conv_done, conv_count,
    input  ch_sel, conv_start, res_valid, res_ch, res_data, busy, err_timeout, state_dbg
  );
endinterface

// File: rtl/conv_sched.sv
// Round-robin scheduler for a shared ramp/counter conversion core with per-channel averaging.
// Optional macro CONV_SCHED_DROP_FIRST_EN: discard the first conversion after every channel select.
module conv_sched #(
  parameter int NCH      = 4,
  parameter int CW       = 9,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 1023
) (
  input logic         clk,
  input logic         rst,
  conv_sched_if.master bus
);
  // Handshakes: conv_start is a one-cycle request; the core answers with a
  // one-cycle conv_done (count valid with it), honoured only in WAIT.
  // res_valid is a one-cycle strobe with no backpressure; res_ch/res_data
  // stay stable until the next strobe.

  localparam int CHW = $clog2(NCH);
  localparam int AW  = CW + AVG_LOG2;
  localparam int NS  = 1 << AVG_LOG2;
  localparam int NW  = AVG_LOG2 + 1;
  localparam int SW  = $clog2(SETTLE + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

`ifdef CONV_SCHED_DROP_FIRST_EN
  localparam bit DROP_FIRST = 1'b1;
`else
  localparam bit DROP_FIRST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, REPORT} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_sel_q, ch_sel_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] res_ch_q, res_ch_d;
  logic [CW-1:0]  res_data_q, res_data_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [NW-1:0]  smp_q, smp_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [TW-1:0]  wait_q, wait_d;
  logic           err_q, err_d;
  logic           discard_q, discard_d;
  logic [CW-1:0]  sample;
  logic           take;
  logic [CHW-1:0] next_ch;

  // First set mask bit at index >= from, wrapping around the channel ring.
  function automatic logic [CHW-1:0] pick(input logic [NCH-1:0] mask, input logic [CHW-1:0] from);
    logic [CHW-1:0] r;
    logic           found;
    int             idx;
    r     = from;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(from) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && mask[idx]) begin
        r     = CHW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign next_ch = (ch_sel_q == CHW'(NCH - 1)) ? '0 : ch_sel_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_sel_q   <= '0;
      ptr_q      <= '0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      acc_q      <= '0;
      smp_q      <= '0;
      settle_q   <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_sel_q   <= ch_sel_d;
      ptr_q      <= ptr_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      acc_q      <= acc_d;
      smp_q      <= smp_d;
      settle_q   <= settle_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_sel_d   = ch_sel_q;
    ptr_d      = ptr_q;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    acc_d      = acc_q;
    smp_d      = smp_q;
    settle_d   = settle_q;
    wait_d     = wait_q;
    err_d      = err_q;
    discard_d  = discard_q;
    sample     = '0;
    take       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.en && (|bus.ch_mask)) begin
          ch_sel_d = pick(bus.ch_mask, ptr_q);
          settle_d = '0;
          state_d  = SELECT;
        end
      end

      SELECT: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SW'(SETTLE - 1)) begin
          discard_d = DROP_FIRST;
          state_d   = START;
        end
      end

      START: begin
        wait_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // A done on the final timeout cycle takes priority over the timeout.
        if (bus.conv_done) begin
          take   = 1'b1;
          sample = bus.conv_count;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          take   = 1'b1;
          sample = '1;
          err_d  = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end

        if (take) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = START;
          end else begin
            acc_d = acc_q + AW'(sample);
            smp_d = smp_q + 1'b1;
            if (smp_q == NW'(NS - 1)) begin
              res_ch_d   = ch_sel_q;
              res_data_d = CW'(acc_d >> AVG_LOG2);
              state_d    = REPORT;
            end else begin
              state_d = START;
            end
          end
        end
      end

      REPORT: begin
        acc_d = '0;
        smp_d = '0;
        ptr_d = next_ch;
        if (bus.en && (|bus.ch_mask)) begin
          ch_sel_d = pick(bus.ch_mask, next_ch);
          settle_d = '0;
          state_d  = SELECT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ch_sel      = ch_sel_q;
  assign bus.conv_start  = (state_q == START);
  assign bus.res_valid   = (state_q == REPORT);
  assign bus.res_ch      = res_ch_q;
  assign bus.res_data    = res_data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_timeout = err_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Multi-channel scheduler for the shared ramp/counter conversion core (discharge, count until comparator trips, latch count).
- Round-robins over enabled sensor channels and drives the analog input mux select.
- Issues one-cycle start pulses to the core and collects its done/count handshake.
- Averages 2^AVG_LOG2 conversions per channel and emits one tagged result per channel visit.

Parameters:
- NCH, 4, number of sensor channels (>=2).
- CW, 9, conversion count width (matches core counter).
- AVG_LOG2, 2, log2 of samples averaged per result (0 = no averaging).
- SETTLE, 4, cycles of mux settling after a channel select (>=1).
- TIMEOUT, 1023, max WAIT cycles before a conversion is declared hung.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset.
- en, input, 1, scan enable (level).
- ch_mask, input, NCH, per-channel enable.
- ch_sel, output, $clog2(NCH), analog mux select.
- conv_start, output, 1, one-cycle start pulse to conversion core.
- conv_done, input, 1, core result valid (one-cycle pulse).
- conv_count, input, CW, core count, valid when conv_done=1.
- res_valid, output, 1, one-cycle result strobe.
- res_ch, output, $clog2(NCH), channel of result.
- res_data, output, CW, averaged count.
- busy, output, 1, high in every state except IDLE.
- err_timeout, output, 1, sticky hung-conversion flag.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE. All outputs go to 0: ch_sel, conv_start, res_valid, res_ch, res_data, busy, err_timeout.
  - Accumulator, sample count, settle/wait counters and round-robin pointer ptr are cleared.
  - rst overrides everything in any state, including mid-WAIT. conv_done in that cycle is ignored.
- States: IDLE, SELECT, START, WAIT, REPORT.
- IDLE: if en=1 and ch_mask!=0, load ch_sel with the first set mask bit at index >= ptr (wrapping), then go to SELECT. Otherwise stay in IDLE.
- SELECT: hold ch_sel for exactly SETTLE cycles, then go to START.
- START: conv_start=1 for exactly this one cycle, then go to WAIT. The wait counter clears.
- WAIT:
  - On conv_done=1: add conv_count (zero-extended) into the accumulator, which is CW+AVG_LOG2 bits and never overflows. Increment the sample count.
  - If the sample count reaches 2^AVG_LOG2, go to REPORT; else go to START.
  - If TIMEOUT consecutive WAIT cycles pass with no conv_done: set err_timeout, accumulate 2^CW-1 (saturated value), and advance as if done.
  - If conv_done arrives on the final timeout cycle, done wins and no error is flagged.
- conv_done outside WAIT is ignored.
- REPORT (single cycle):
  - res_valid=1, res_ch=ch_sel, res_data = accumulator >> AVG_LOG2 (truncate).
  - res_ch and res_data hold their values until the next REPORT.
  - Clear the accumulator and sample count. Set ptr = ch_sel+1 (mod NCH).
  - Next state: if en=1 and ch_mask!=0, load the next set bit strictly after ch_sel (wrapping) and go to SELECT. A single-bit mask reselects the same channel, still with SETTLE. Otherwise go to IDLE.
- en deasserted mid-channel: the current channel runs through REPORT, then the block returns to IDLE.
- ch_mask changes are sampled only at channel selection. A channel masked off mid-visit still completes.
- Latency: with en rising in IDLE at cycle 0, SELECT occupies cycles 1..SETTLE and conv_start is high at cycle SETTLE+1.
- err_timeout clears only on rst.

Optional Feature:
- Macro: CONV_SCHED_DROP_FIRST_EN.
- When defined: after each SELECT, the first conversion is run but discarded (not accumulated, not counted). Timeout detection still applies to it. Each channel visit then issues 2^AVG_LOG2+1 start pulses.
- When undefined: every conversion is accumulated, giving 2^AVG_LOG2 start pulses per visit.

Test Plan:
- Defaults, mask=4'b0101, en=1, core returns 100,101,102,103 on ch0 -> one res_valid with res_ch=0, res_data=101 (406>>2); ch_sel then goes to 2 and SETTLE=4 cycles later conv_start pulses.
- en rises at cycle 0 in IDLE -> conv_start high only at cycle 5; exactly one pulse per conversion; busy=1 from cycle 1.
- conv_done withheld for 1023 WAIT cycles on the first sample, other three return 0 -> err_timeout=1 and stays high; res_data=127 (511>>2); the scan continues.
- mask=4'b1000, en=1 -> ch_sel stays 3 for every visit and SETTLE is repeated each visit; en dropped mid-WAIT -> REPORT completes, then IDLE with busy=0 and no further conv_start.
- rst=1 during WAIT with conv_done=1 in the same cycle -> next cycle all outputs are 0 and no res_valid is produced; ch_mask=0 with en=1 -> stays IDLE and busy=0.
- With CONV_SCHED_DROP_FIRST_EN, counts 500,10,10,10,10 -> res_data=10 and 5 conv_start pulses per visit.
